ldl_fifo_rd_sched: RTL and testbench
====================================

# ldl_fifo_rd_sched

Round-robin read scheduler that drains up to N show-ahead FIFO read sides (AHEAD=1 read-side controllers) onto one registered valid/ready output stream. It owns the `re` strobe of every FIFO, grants one queue at a time for a bounded burst, and tags each output word with its source queue index. It sits between a bank of per-source FIFOs and a single shared downstream consumer.

## Interface
- N, 4, number of FIFO read sides (2..16); ID width IW = $clog2(N) derived locally
- DW, 32, data word width
- BURST, 8, max words popped per grant (1..256); burst counter width $clog2(BURST)+1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  N  per-queue enable; 0 excludes the queue from arbitration and ends its grant
- empty  in  N  per-FIFO empty flag (registered by the FIFO)
- rdata  in  N*DW  per-FIFO show-ahead data; queue i at bits [i*DW +: DW], valid while empty[i]==0
- re  out  N  per-FIFO read strobe, at most one bit set
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_data  out  DW  output word
- out_id  out  IW  source queue of out_data
- busy  out  1  1 while in GRANT

## Operation
- State machine: IDLE, GRANT. Registers: state, g (granted index), last (last served index), cnt (pops in current grant), output stage.
- Reset values: state=IDLE, g=0, last=N-1, cnt=0, out_valid=0, out_data=0, out_id=0; hence re=0, busy=0.
- IDLE: cand = en & ~empty. If cand==0 stay. Else g <= first set bit of cand searching last+1, last+2, ... modulo N; cnt <= 0; -> GRANT. No pop in IDLE.
- GRANT, free = ~out_valid | out_ready.
  - re[g] = en[g] & ~empty[g] & free (combinational, only in GRANT).
  - On pop: out_data <= rdata[g], out_id <= g, out_valid <= 1, cnt <= cnt+1. If cnt == BURST-1: last <= g, -> IDLE.
  - If en[g]==0 or empty[g]==1: no pop; last <= g; -> IDLE.
  - Else (free==0): hold all state; cnt unchanged.
- Output stage: if out_valid & out_ready & no pop this cycle, out_valid <= 0. out_data/out_id change only on pop.
- Only pops advance cnt; stalled cycles never consume quota.
- Same queue may be re-granted immediately when it is the only candidate.
- rst mid-burst: any held output word is discarded, FIFO pointers are untouched (owned by the FIFOs), and arbitration restarts with queue 0 first.

## Timing
- Arbitration bubble: one IDLE cycle before every grant; sustained rate BURST words per BURST+1 cycles with out_ready=1.
- Pop-to-output latency: 1 cycle (re[g] in cycle t -> out_valid/out_data at t+1).
- First word: empty[i] falls in cycle t (all idle) -> IDLE grants at t, re[i] at t+1, out_valid at t+2.
- Last word of a FIFO: pop at t; the FIFO raises empty at t+1; scheduler sees it at t+1 and returns to IDLE (no pop at t+1).
- empty and rdata are sampled combinationally in the same cycle as re; no extra registering inside this block.
- re never asserted for a queue with empty=1 or en=0; no read while out_valid & ~out_ready.

## Test plan
- Reset: hold rst 3 cycles with random inputs -> re=0, out_valid=0, out_data=0, out_id=0, busy=0; release with all queues loaded -> first grant is queue 0.
- Single source: N=4, BURST=8, queue 2 holds A,B,C, out_ready=1 -> re[2] on 3 consecutive cycles, out words A,B,C with out_id=2 back-to-back, then IDLE, busy=0.
- Fairness: N=4, BURST=4, each queue holds 10 words -> out_id order 0×4,1×4,2×4,3×4,0×4,...,ending 2×2,3×2; 40 words, one bubble between bursts, no word lost or duplicated.
- Backpressure: out_ready=0 for 5 cycles after second pop of a burst -> out_data/out_id stable, re=0, cnt stays 2; burst completes with 2 more pops after release.
- Enable drop: clear en[1] during queue 1's burst after 2 pops -> no further re[1], grant moves to queue 2 after one IDLE cycle; queue 1 data remains in FIFO.
- Reset mid-burst: assert rst during queue 3's burst with out_valid=1, out_ready=0 -> next cycle out_valid=0, state IDLE; after release queue 0 is granted first.

Source files
------------

// File: rtl/ldl_fifo_rd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ldl_fifo_rd_sched                                             |
// | Purpose  : Round-robin read scheduler. Drains up to N show-ahead FIFO    |
// |            read sides onto one registered valid/ready stream. It grants  |
// |            one queue at a time for a burst of at most BURST pops and     |
// |            tags each output word with its source queue index.           |
// | Ports    : clk, rst        - clock, synchronous active-high reset        |
// |            en[N]           - per-queue enable (0 = excluded/end grant)   |
// |            empty[N]        - per-FIFO empty flag                         |
// |            rdata[N*DW]     - per-FIFO show-ahead word, queue i at i*DW   |
// |            re[N]           - per-FIFO read strobe (one-hot or zero)      |
// |            out_valid/out_ready/out_data/out_id - output stream         |
// |            busy            - high while a queue is granted               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ldl_fifo_rd_sched #(
  parameter int N     = 4,
  parameter int DW    = 32,
  parameter int BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         en,
  input  logic [N-1:0]         empty,
  input  logic [N*DW-1:0]      rdata,
  output logic [N-1:0]         re,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(BURST - 1);
  localparam logic [IW-1:0] C_LAST_RST = IW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   g_q, g_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [IW-1:0]   out_id_q, out_id_d;

  logic [N-1:0]    w_cand;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_idx;
  logic            w_found;
  logic [DW-1:0]   w_gdata;
  logic            w_gen;
  logic            w_gempty;
  logic            w_free;
  logic            w_gok;
  logic            w_pop;

  assign w_cand = en & ~empty;

  // Rotating priority search starting just after the last served queue.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(last_q) + k) % N);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Select the granted queue's data and status.
  always_comb begin
    w_gdata  = '0;
    w_gen    = 1'b0;
    w_gempty = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (g_q == IW'(i)) begin
        w_gdata  = rdata[i*DW +: DW];
        w_gen    = en[i];
        w_gempty = empty[i];
      end
    end
  end

  // A pop needs room in the output register: empty, or draining this cycle.
  assign w_free = ~out_valid_q | out_ready;
  assign w_gok  = w_gen & ~w_gempty;
  assign w_pop  = (state_q == S_GRANT) & w_gok & w_free;

  always_comb begin
    re = '0;
    for (int i = 0; i < N; i++) begin
      re[i] = w_pop & (g_q == IW'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          g_d     = w_pick;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_pop) begin
          out_data_d  = w_gdata;
          out_id_d    = g_q;
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == C_CNT_LAST) begin
            last_d  = g_q;
            state_d = S_IDLE;
          end
        end else if (!w_gok) begin
          // Queue drained or disabled: give up the grant without a pop.
          last_d  = g_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      last_q      <= C_LAST_RST;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q == S_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_ldl_fifo_rd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ldl_fifo_rd_sched                                          |
// | Purpose  : Directed self-checking bench for ldl_fifo_rd_sched (N=4,      |
// |            DW=32, BURST=4) with simple show-ahead FIFO models.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ldl_fifo_rd_sched;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int BURST = 4;
  localparam int IW    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      en = '0;
  logic [N-1:0]      empty;
  logic [N*DW-1:0]   rdata;
  logic [N-1:0]      re;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_id;
  logic              busy;

  int n_asserts = 0;
  int n_fail    = 0;

  // FIFO models: head advances on re, tail advances on bench pushes.
  logic [31:0] mem [N][256];
  int          head [N] = '{default: 0};
  int          tail [N] = '{default: 0};

  always #5 clk = ~clk;

  always_comb begin
    empty = '1;
    rdata = '0;
    for (int i = 0; i < N; i++) begin
      empty[i]           = (head[i] == tail[i]);
      rdata[i*DW +: DW]  = mem[i][8'(head[i])];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (re[i]) head[i] <= head[i] + 1;
    end
  end

  ldl_fifo_rd_sched #(.N(N), .DW(DW), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .empty     (empty),
    .rdata     (rdata),
    .re        (re),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  function automatic logic [31:0] wd(int tag, int q, int s);
    return {8'(tag), 8'(q), 16'(s)};
  endfunction

  task automatic push(int q, logic [31:0] d);
    mem[q][8'(tail[q])] = d;
    tail[q] = tail[q] + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) tail[i] = head[i];
    en        = '0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    en        = 4'($urandom);
    out_ready = 1'($urandom);
    for (int q = 0; q < N; q++) push(q, wd(8'h11, q, 0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_asserts++;
      if (re !== 4'b0000) begin n_fail++; $display("FAIL reset_re c%0d got %b expected 0000", c, re); end
      n_asserts++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid c%0d got %b expected 0", c, out_valid); end
      n_asserts++;
      if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data c%0d got %h expected 0", c, out_data); end
      n_asserts++;
      if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_id c%0d got %0d expected 0", c, out_id); end
      n_asserts++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy c%0d got %b expected 0", c, busy); end
      en = 4'($urandom);
    end
    en        = '1;
    out_ready = 1'b1;
    rst       = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (re !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant re got %b expected 0001", re); end
  endtask

  task automatic test_single_source();
    logic [3:0]  exp_re   [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic        exp_v    [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_d    [5] = '{32'h0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'h0};
    do_reset();
    push(2, 32'hAAAA0001);
    push(2, 32'hBBBB0002);
    push(2, 32'hCCCC0003);
    en = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_asserts++;
      if (re !== exp_re[c]) begin n_fail++; $display("FAIL single_re c%0d got %b expected %b", c, re, exp_re[c]); end
      n_asserts++;
      if (out_valid !== exp_v[c]) begin n_fail++; $display("FAIL single_valid c%0d got %b expected %b", c, out_valid, exp_v[c]); end
      n_asserts++;
      if (busy !== exp_busy[c]) begin n_fail++; $display("FAIL single_busy c%0d got %b expected %b", c, busy, exp_busy[c]); end
      if (exp_v[c]) begin
        n_asserts++;
        if (out_data !== exp_d[c] || out_id !== 2'd2) begin
          n_fail++; $display("FAIL single_word c%0d got %h/%0d expected %h/2", c, out_data, out_id, exp_d[c]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int          nw = 0;
    int          got_cyc [64];
    logic [31:0] got_d   [64];
    logic [1:0]  got_id  [64];
    int          exp_q   [40];
    int          exp_s   [40];
    int          k = 0;
    int          gap;
    do_reset();
    for (int q = 0; q < N; q++)
      for (int s = 0; s < 10; s++) push(q, wd(8'hF0, q, s));
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < N; q++)
        for (int s = 0; s < ((r < 2) ? 4 : 2); s++) begin
          exp_q[k] = q; exp_s[k] = r*4 + s; k++;
        end
    en = '1;
    for (int cyc = 0; cyc < 200 && nw < 40; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got_cyc[nw] = cyc; got_d[nw] = out_data; got_id[nw] = out_id; nw++;
      end
    end
    n_asserts++;
    if (nw != 40) begin n_fail++; $display("FAIL fair_count got %0d expected 40", nw); end
    for (int j = 0; j < nw; j++) begin
      n_asserts++;
      if (got_id[j] !== 2'(exp_q[j]) || got_d[j] !== wd(8'hF0, exp_q[j], exp_s[j])) begin
        n_fail++; $display("FAIL fair_word %0d got %h/%0d expected %h/%0d", j, got_d[j], got_id[j], wd(8'hF0, exp_q[j], exp_s[j]), exp_q[j]);
      end
      if (j > 0) begin
        if (j < 32) gap = (j % 4 == 0) ? 2 : 1;
        else if (j == 32) gap = 2;
        else gap = ((j - 32) % 2 == 0) ? 3 : 1;
        n_asserts++;
        if (got_cyc[j] - got_cyc[j-1] != gap) begin
          n_fail++; $display("FAIL fair_gap %0d got %0d expected %0d", j, got_cyc[j] - got_cyc[j-1], gap);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_asserts++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || empty !== 4'b1111) begin
      n_fail++; $display("FAIL fair_end got busy=%b valid=%b empty=%b expected 0 0 1111", busy, out_valid, empty);
    end
  endtask

  task automatic test_backpressure();
    int          nacc = 0;
    int          npop = 0;
    logic [31:0] acc [8];
    do_reset();
    for (int s = 0; s < 4; s++) push(1, wd(8'hB0, 1, s));
    en = '1;
    @(negedge clk);
    n_asserts++;
    if (re !== 4'b0010) begin n_fail++; $display("FAIL bp_grant re got %b expected 0010", re); end
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_asserts++;
    if (re !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_re got %b expected 0000", re); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_asserts++;
      if (out_valid !== 1'b1 || out_data !== wd(8'hB0, 1, 1) || out_id !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold c%0d got %b %h/%0d expected 1 %h/1", c, out_valid, out_data, out_id, wd(8'hB0, 1, 1));
      end
      n_asserts++;
      if (re !== 4'b0000) begin n_fail++; $display("FAIL bp_re c%0d got %b expected 0000", c, re); end
      n_asserts++;
      if (dut.cnt_q !== 3'd2) begin n_fail++; $display("FAIL bp_cnt c%0d got %0d expected 2", c, dut.cnt_q); end
    end
    out_ready = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid && out_ready) begin acc[nacc] = out_data; nacc++; end
      if (re != 4'b0000) npop++;
      @(negedge clk);
    end
    n_asserts++;
    if (npop != 2) begin n_fail++; $display("FAIL bp_pops got %0d expected 2", npop); end
    n_asserts++;
    if (nacc != 3) begin n_fail++; $display("FAIL bp_accepted got %0d expected 3", nacc); end
    else begin
      for (int j = 0; j < 3; j++) begin
        n_asserts++;
        if (acc[j] !== wd(8'hB0, 1, j + 1)) begin
          n_fail++; $display("FAIL bp_word %0d got %h expected %h", j, acc[j], wd(8'hB0, 1, j + 1));
        end
      end
    end
    n_asserts++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_end_busy got %b expected 0", busy); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    for (int s = 0; s < 6; s++) begin
      push(1, wd(8'hE1, 1, s));
      push(2, wd(8'hE2, 2, s));
    end
    en = '1;
    repeat (3) @(negedge clk);
    en[1] = 1'b0;
    #1;
    n_asserts++;
    if (re !== 4'b0000) begin n_fail++; $display("FAIL endrop_re got %b expected 0000", re); end
    @(negedge clk);
    n_asserts++;
    if (busy !== 1'b0 || re !== 4'b0000) begin n_fail++; $display("FAIL endrop_idle got busy=%b re=%b expected 0 0000", busy, re); end
    @(negedge clk);
    n_asserts++;
    if (re !== 4'b0100 || busy !== 1'b1) begin n_fail++; $display("FAIL endrop_next got re=%b busy=%b expected 0100 1", re, busy); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_asserts++;
      if (re[1] !== 1'b0) begin n_fail++; $display("FAIL endrop_no_re1 c%0d got %b expected 0", c, re[1]); end
    end
    n_asserts++;
    if (tail[1] - head[1] != 4) begin n_fail++; $display("FAIL endrop_q1_left got %0d expected 4", tail[1] - head[1]); end
    n_asserts++;
    if (tail[2] - head[2] != 0) begin n_fail++; $display("FAIL endrop_q2_left got %0d expected 0", tail[2] - head[2]); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int s = 0; s < 6; s++) push(3, wd(8'hD3, 3, s));
    en = '1;
    @(negedge clk);
    n_asserts++;
    if (re !== 4'b1000) begin n_fail++; $display("FAIL rmid_grant re got %b expected 1000", re); end
    @(negedge clk);
    n_asserts++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid got %b expected 1", out_valid); end
    out_ready = 1'b0;
    rst       = 1'b1;
    push(0, wd(8'hD0, 0, 0));
    push(0, wd(8'hD0, 0, 1));
    @(negedge clk);
    n_asserts++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || re !== 4'b0000 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL rmid_reset got valid=%b busy=%b re=%b data=%h expected 0 0 0000 0", out_valid, busy, re, out_data);
    end
    n_asserts++;
    if (tail[3] - head[3] != 5) begin n_fail++; $display("FAIL rmid_q3_left got %0d expected 5", tail[3] - head[3]); end
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_asserts++;
    if (re !== 4'b0001) begin n_fail++; $display("FAIL rmid_first_grant re got %b expected 0001", re); end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_fairness();
    test_backpressure();
    test_enable_drop();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached, expected completion earlier");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
